// File: rtl/id_scoreboard_pkg.sv
// Shared constants and types for the decode-stage register scoreboard.
// Combinational definitions only; no latency.
// No flow control of its own.
package id_scoreboard_pkg;

    // Control-level encodings used throughout the decode pipeline
    localparam logic RstEnable   = 1'b1;
    localparam logic NoStop      = 1'b0;
    localparam logic Stop        = 1'b1;
    localparam logic ReadEnable  = 1'b1;
    localparam logic WriteEnable = 1'b1;

    // Default geometry of the architectural register file
    localparam int REG_NUM_DEF = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int LAT_W_DEF   = 3;

    // Per-cycle action applied to one register's latency counter
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_DEC  = 2'd1,
        CNT_LOAD = 2'd2,
        CNT_CLR  = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/id_scoreboard_sb_counter.sv
// Single register's remaining-latency counter: load, saturating decrement, clear, hold.
// Counter updates on the clock edge after op_i is presented; nz_next_o is combinational.
// No backpressure; the parent decides the op each cycle.
module sb_counter
    import id_scoreboard_pkg::*;
#(
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  cnt_op_e          op_i,
    input  logic [LAT_W-1:0] load_val_i,
    output logic             nz_o,
    output logic             nz_next_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    // Next counter value from the requested operation; decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        case (op_i)
            CNT_HOLD: cnt_d = cnt_q;
            CNT_DEC:  if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            CNT_LOAD: cnt_d = load_val_i;
            CNT_CLR:  cnt_d = '0;
        endcase
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nz_o      = (cnt_q != '0);
    assign nz_next_o = (cnt_d != '0);

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage RAW scoreboard: per-register countdown of cycles until a result is forwardable.
// Hazard flags and stall request are combinational; busy count is registered with counter state.
// stall_i freezes all counters; flush_i clears them; issues are taken only when nothing blocks.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LAT_W   = LAT_W_DEF,
    parameter int NUM_SRC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid_i,
    input  logic                      issue_wreg_i,
    input  logic [ADDR_W-1:0]         issue_wd_i,
    input  logic [LAT_W-1:0]          issue_lat_i,
    input  logic [NUM_SRC-1:0]        src_read_i,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    output logic                      stallreq_o,
    output logic [NUM_SRC-1:0]        src_pending_o,
    output logic [ADDR_W:0]           busy_cnt_o
);

    // Full address space; slots 0 and >= REG_NUM are hardwired idle so any
    // address can index these vectors without a separate range check.
    localparam int SPACE = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [SPACE-1:0]   nz_cur;
    logic [SPACE-1:0]   nz_nxt;
    logic               accept;
    logic               load_en;
    logic [CNT_W-1:0]   busy_cnt_q;
    logic [CNT_W-1:0]   busy_cnt_d;
    logic [NUM_SRC-1:0] pending;

    // Per-source hazard: read enabled and the addressed register still counting
    always_comb begin
        pending = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pending[k] = (src_read_i[k] == ReadEnable)
                       && nz_cur[src_addr_i[k*ADDR_W +: ADDR_W]];
        end
    end

    assign src_pending_o = pending;
    assign stallreq_o    = (|pending) ? Stop : NoStop;

    // An issue only lands when decode is not stalling itself and the pipe is moving
    assign accept  = issue_valid_i && (stallreq_o == NoStop) && !stall_i && !flush_i;
    assign load_en = accept && (issue_wreg_i == WriteEnable) && (issue_lat_i != '0);

    for (genvar r = 0; r < SPACE; r++) begin : g_reg
        if (r == 0 || r >= REG_NUM) begin : g_untracked
            assign nz_cur[r] = 1'b0;
            assign nz_nxt[r] = 1'b0;
        end else begin : g_tracked
            cnt_op_e op;
            logic    load_hit;

            assign load_hit = load_en && (issue_wd_i == ADDR_W'(r));

            // Flush beats a freeze, a freeze beats the issue, and a new issue beats the countdown
            always_comb begin
                op = CNT_DEC;
                if (flush_i) begin
                    op = CNT_CLR;
                end else if (stall_i) begin
                    op = CNT_HOLD;
                end else if (load_hit) begin
                    op = CNT_LOAD;
                end
            end

            sb_counter #(
                .LAT_W (LAT_W)
            ) u_cnt (
                .clk        (clk),
                .rst        (rst),
                .op_i       (op),
                .load_val_i (issue_lat_i),
                .nz_o       (nz_cur[r]),
                .nz_next_o  (nz_nxt[r])
            );
        end
    end

    // Number of registers that will still be counting after this edge
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < SPACE; i++) begin
            busy_cnt_d = busy_cnt_d + CNT_W'(nz_nxt[i]);
        end
    end

    // Busy count register, tracking counter contents edge for edge
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            busy_cnt_q <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_id_scoreboard.sv
module tb_id_scoreboard;

    localparam int REG_NUM = 32;
    localparam int ADDR_W  = 5;
    localparam int LAT_W   = 3;
    localparam int NUM_SRC = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      issue_valid_i;
    logic                      issue_wreg_i;
    logic [ADDR_W-1:0]         issue_wd_i;
    logic [LAT_W-1:0]          issue_lat_i;
    logic [NUM_SRC-1:0]        src_read_i;
    logic [NUM_SRC*ADDR_W-1:0] src_addr_i;
    logic                      stall_i;
    logic                      flush_i;
    logic                      stallreq_o;
    logic [NUM_SRC-1:0]        src_pending_o;
    logic [ADDR_W:0]           busy_cnt_o;

    id_scoreboard #(
        .REG_NUM (REG_NUM),
        .ADDR_W  (ADDR_W),
        .LAT_W   (LAT_W),
        .NUM_SRC (NUM_SRC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid_i (issue_valid_i),
        .issue_wreg_i  (issue_wreg_i),
        .issue_wd_i    (issue_wd_i),
        .issue_lat_i   (issue_lat_i),
        .src_read_i    (src_read_i),
        .src_addr_i    (src_addr_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .stallreq_o    (stallreq_o),
        .src_pending_o (src_pending_o),
        .busy_cnt_o    (busy_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: cycles remaining until each register's value is forwardable
    int model[REG_NUM];
    logic last_stallreq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_pending(input logic rd, input logic [ADDR_W-1:0] a);
        int ai;
        ai = int'(a);
        return rd && ai != 0 && ai < REG_NUM && model[ai] > 0;
    endfunction

    task automatic drive(input logic v, input logic w, input int wd, input int lat,
                         input logic [1:0] rd, input int a0, input int a1,
                         input logic st, input logic fl, input logic rs);
        issue_valid_i = v;
        issue_wreg_i  = w;
        issue_wd_i    = ADDR_W'(wd);
        issue_lat_i   = LAT_W'(lat);
        src_read_i    = rd;
        src_addr_i    = {ADDR_W'(a1), ADDR_W'(a0)};
        stall_i       = st;
        flush_i       = fl;
        rst           = rs;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    // One clock: check hazard outputs against the model, advance the model
    // across the edge, then check the busy count it should now show.
    task automatic step();
        logic [1:0] exp_pend;
        logic       exp_stall;
        bit         acc;
        int         busy;
        #2;
        exp_pend[0] = model_pending(src_read_i[0], src_addr_i[ADDR_W-1:0]);
        exp_pend[1] = model_pending(src_read_i[1], src_addr_i[2*ADDR_W-1:ADDR_W]);
        exp_stall   = |exp_pend;
        chk("src_pending", 32'(src_pending_o), 32'(exp_pend));
        chk("stallreq", 32'(stallreq_o), 32'(exp_stall));
        last_stallreq = stallreq_o;
        acc = issue_valid_i && !exp_stall && !stall_i && !flush_i;
        @(posedge clk);
        if (rst || flush_i) begin
            foreach (model[i]) model[i] = 0;
        end else if (!stall_i) begin
            for (int r = 1; r < REG_NUM; r++) begin
                if (acc && issue_wreg_i && int'(issue_wd_i) == r && issue_lat_i != 0)
                    model[r] = int'(issue_lat_i);
                else if (model[r] > 0)
                    model[r] = model[r] - 1;
            end
        end
        busy = 0;
        foreach (model[i]) if (model[i] > 0) busy++;
        #1;
        chk("busy_cnt", 32'(busy_cnt_o), 32'(busy));
    endtask

    initial begin
        int stalls;
        foreach (model[i]) model[i] = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        idle();
        chk("reset_busy", 32'(busy_cnt_o), 32'd0);
        chk("reset_stallreq", 32'(stallreq_o), 32'd0);

        // r5 lat 3, then read it: three stall cycles then clear
        drive(1, 1, 5, 3, 2'b00, 0, 0, 0, 0, 0); step();
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 2'b01, 5, 0, 0, 0, 0); step();
            if (last_stallreq) stalls++;
        end
        chk("r5_stall_cycles", 32'(stalls), 32'd3);
        chk("r5_fourth_clear", 32'(last_stallreq), 32'd0);

        // r0 is never tracked
        drive(1, 1, 0, 7, 2'b01, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0); step();
        end

        // r7 lat 2 frozen for 4 cycles, read on source 1
        drive(1, 1, 7, 2, 2'b00, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 2'b10, 0, 7, 1, 0, 0); step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 2'b10, 0, 7, 0, 0, 0); step();
        end

        // r9 reloaded while at 1
        drive(1, 1, 9, 2, 2'b00, 0, 0, 0, 0, 0); step();
        idle(); step();
        drive(1, 1, 9, 4, 2'b00, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 2'b01, 9, 0, 0, 0, 0); step();
        end

        // r3/r4 flushed
        drive(1, 1, 3, 6, 2'b00, 0, 0, 0, 0, 0); step();
        drive(1, 1, 4, 5, 2'b00, 0, 0, 0, 0, 0); step();
        drive(1, 1, 6, 7, 2'b11, 3, 4, 0, 1, 0); step();
        drive(0, 0, 0, 0, 2'b11, 3, 4, 0, 0, 0); step();
        chk("flush_busy_zero", 32'(busy_cnt_o), 32'd0);

        // r12 pending; blocked issue, then reset mid-countdown
        drive(1, 1, 12, 5, 2'b00, 0, 0, 0, 0, 0); step();
        drive(1, 1, 13, 3, 2'b01, 12, 0, 0, 0, 0); step();
        drive(1, 1, 14, 3, 2'b01, 12, 0, 1, 1, 1); step();
        drive(0, 0, 0, 0, 2'b11, 12, 13, 0, 0, 0); step();
        chk("rst_stallreq", 32'(stallreq_o), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 79) == 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
